// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: issue/result bundle between the EX stage and the muldiv sequencer.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic start, flush, busy, done;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, hi, lo;
  modport master(output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave(input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative shift-add multiplier / restoring divider owning HI/LO.
module muldiv_ctrl #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic is_div_q, is_div_d, neg_q, neg_d, neg_r_q, neg_r_d, done_q, done_d;
  logic is_signed, arith, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [WIDTH:0] msum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    is_signed = ~bus.op[0];
    arith = ~bus.op[2];
    sa = is_signed & bus.a[WIDTH-1];
    sb = is_signed & bus.b[WIDTH-1];
    mag_a = sa ? -bus.a : bus.a;
    mag_b = sb ? -bus.b : bus.b;
    msum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff = shifted - {1'b0, opnd_q};
    prod = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo = neg_q ? -acc_lo_q : acc_lo_q;
    rem = neg_r_q ? -acc_hi_q : acc_hi_q;
    state_d = state_q;
    count_d = count_q;
    hi_d = hi_q;
    lo_d = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d = opnd_q;
    is_div_d = is_div_q;
    neg_d = neg_q;
    neg_r_d = neg_r_q;
    done_d = 1'b0;
    if (bus.flush) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (bus.start && arith) begin
        state_d = CALC;
        count_d = '0;
        is_div_d = bus.op[1];
        // divide-by-zero keeps an all-ones quotient regardless of operand signs
        neg_d = (sa ^ sb) & ~(bus.op[1] & (bus.b == '0));
        neg_r_d = sa;
        acc_hi_d = '0;
        acc_lo_d = bus.op[1] ? mag_a : mag_b;
        opnd_d = bus.op[1] ? mag_b : mag_a;
      end else if (bus.start && bus.op[2:1] == 2'b10) begin
        hi_d = bus.op[0] ? hi_q : bus.a;
        lo_d = bus.op[0] ? bus.a : lo_q;
      end
    end else if (state_q == CALC) begin
      count_d = count_q + CW'(1);
      state_d = (count_q == CW'(WIDTH-1)) ? FIX : CALC;
      acc_hi_d = is_div_q ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : msum[WIDTH:1];
      acc_lo_d = is_div_q ? {acc_lo_q[WIDTH-2:0], ~diff[WIDTH]} : {msum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      state_d = IDLE;
      done_d = 1'b1;
      hi_d = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = is_div_q ? quo : prod[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q <= '0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q <= opnd_d;
      is_div_q <= is_div_d;
      neg_q <= neg_d;
      neg_r_q <= neg_r_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl against an arithmetic model.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  muldiv_ctrl_if #(.WIDTH(32)) bus();
  muldiv_ctrl #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int q, r;
    if (o == 3'd0) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    if (o == 3'd1) return {32'b0, x} * {32'b0, y};
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (o == 3'd2) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
      return {r, q};
    end
    return {x % y, x / y};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int busy_cyc, done_cyc, n;
    logic [63:0] exp;
    exp = model(o, x, y);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    busy_cyc = 0;
    done_cyc = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      busy_cyc++;
      n++;
      bus.start = (n == 5);
      if (n == 5) bus.op = 3'b101;
      tick();
      if (bus.done) done_cyc++;
    end
    chk({tag, "_busy"}, 64'(busy_cyc), 64'd33);
    chk({tag, "_done"}, 64'(done_cyc), 64'd1);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
  endtask

  initial begin
    logic [31:0] h0, l0, x, y;
    logic [2:0] o;
    bus.start = 1'b0;
    bus.op = 3'b0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, "mult_neg");
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(3'd3, 32'd100, 32'd7, "divu");
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(3'd3, 32'h1234, 32'd0, "divu_zero");
    run_op(3'd2, 32'hFFFFFF00, 32'd0, "div_zero_neg");
    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.a = 32'hA5A5A5A5;
    tick();
    bus.start = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'hA5A5A5A5);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    bus.start = 1'b1;
    bus.op = 3'b101;
    bus.a = 32'h5A5A0001;
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'h5A5A0001);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.op = 3'b101;
    bus.a = 32'h0BADF00D;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_idle_lo", 64'(bus.lo), 64'(l0));
    bus.start = 1'b1;
    bus.op = 3'b000;
    bus.a = 32'd1234;
    bus.b = 32'd5678;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'(h0));
    chk("flush_lo", 64'(bus.lo), 64'(l0));
    repeat (30) tick();
    chk("flush_late_done", 64'(bus.done), 64'd0);
    chk("flush_late_lo", 64'(bus.lo), 64'(l0));
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = $urandom_range(1, 15);
      if ($urandom_range(0, 7) == 0) y = '0;
      run_op(o, x, y, "rand");
    end
    bus.start = 1'b1;
    bus.op = 3'b000;
    bus.a = 32'h7FFF1234;
    bus.b = 32'h00ABCDEF;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_hi", 64'(bus.hi), 64'd0);
    chk("rst_mid_lo", 64'(bus.lo), 64'd0);
    run_op(3'd1, 32'd12345, 32'd678, "multu_after_rst");
    run_op(3'd3, 32'hDEADBEEF, 32'd1000, "divu_b2b");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
